sync_fifo_prog: RTL

//  Single-clock FIFO: parametrised width/depth, selectable read mode (registered or first-word-fall-through),

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_mem.sv | 27 ++
 rtl/sync_fifo_prog.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode encoding and the count-width helper
// used by both the single-clock and dual-clock FIFOs.
package fifo_pkg;

    typedef enum logic {
        FIFO_REG  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // A count must hold 0..DEPTH inclusive, hence one bit more than the address.
    function automatic int fifo_cnt_w(input int awidth);
        return awidth + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: 1-write/1-read register array, synchronous write,
// combinational read, contents deliberately left unreset.
module fifo_mem #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with registered or first-word-fall-through read,
// programmable almost-full/empty thresholds and sticky error flags.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4,
    parameter int FWFT   = 0
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid,
    input  logic [AWIDTH:0]   af_thresh,
    input  logic [AWIDTH:0]   ae_thresh,
    input  logic              err_clr,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AWIDTH:0]   fifo_count,
    output logic              overflow,
    output logic              underflow
);

    localparam int              CW       = fifo_cnt_w(AWIDTH);
    localparam int              DEPTH    = 1 << AWIDTH;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam fifo_mode_e      MODE     = (FWFT != 0) ? FIFO_FWFT : FIFO_REG;

    logic [CW-1:0]     wr_ptr;
    logic [CW-1:0]     rd_ptr;
    logic [CW-1:0]     count_next;
    logic              wr_acc;
    logic              rd_acc;
    logic [DWIDTH-1:0] mem_rd_data;

    // Acceptance uses registered flags only: no pass-through in either direction.
    assign wr_acc     = wr_en & ~fifo_full;
    assign rd_acc     = rd_en & ~fifo_empty;
    assign count_next = fifo_count + CW'(wr_acc) - CW'(rd_acc);

    fifo_mem #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[AWIDTH-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr[AWIDTH-1:0]),
        .rd_data (mem_rd_data)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            fifo_full    <= 1'b0;
            fifo_empty   <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + CW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
            fifo_count   <= count_next;
            fifo_full    <= (count_next == FULL_CNT);
            fifo_empty   <= (count_next == '0);
            almost_full  <= (count_next >= af_thresh);
            almost_empty <= (count_next <= ae_thresh);
        end
    end

    // Setting wins over clearing so a fresh error is never lost to err_clr.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && fifo_full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en && fifo_empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (MODE == FIFO_REG) begin : g_reg
            always_ff @(posedge clk or negedge rstb) begin
                if (!rstb) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_acc;
                    if (rd_acc) begin
                        rd_data <= mem_rd_data;
                    end
                end
            end
        end else begin : g_fwft
            // Head word is shown directly; zeroed while empty so unwritten storage never leaks out.
            assign rd_data  = fifo_empty ? '0 : mem_rd_data;
            assign rd_valid = ~fifo_empty;
        end
    endgenerate

endmodule
